// File: rtl/gpu_hw_regs_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_hw_regs_pkg
//  Description : Shared widths, window defaults and port-select encoding for
//                the GPU hardware register write arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpu_hw_regs_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;
  localparam int HW_REGS_SIZE_DEF = 8;
  localparam logic [ADDR_W-1:0] BASE_WRITE_ADDRESS_DEF = 20'h0;

  // Identifies which requester owns a grant; used for the round-robin memory.
  typedef enum logic {
    PORT_HOST = 1'b0,
    PORT_SCR  = 1'b1
  } port_e;

endpackage : gpu_hw_regs_pkg
`default_nettype wire

// File: rtl/gpu_hw_regs_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_hw_regs_write_arbiter_if
//  Description : Requester handshakes, vblank and register-bank write bus.
//                master = requester/bank side, slave = arbiter side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gpu_hw_regs_write_arbiter_if;
  import gpu_hw_regs_pkg::*;

  logic              host_req;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data;
  logic              host_ack;
  logic              scr_req;
  logic [ADDR_W-1:0] scr_addr;
  logic [DATA_W-1:0] scr_data;
  logic              scr_ack;
  logic              vblank;
  logic              we;
  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] data_out;
  logic [7:0]        drop_cnt;

  modport master (
    output host_req, host_addr, host_data, scr_req, scr_addr, scr_data, vblank,
    input  host_ack, scr_ack, we, addr_out, data_out, drop_cnt
  );

  modport slave (
    input  host_req, host_addr, host_data, scr_req, scr_addr, scr_data, vblank,
    output host_ack, scr_ack, we, addr_out, data_out, drop_cnt
  );

endinterface : gpu_hw_regs_write_arbiter_if
`default_nettype wire

// File: rtl/gpu_hw_regs_write_arbiter_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_rr_pick2
//  Description : Combinational two-way round-robin picker. Bit 0 = host,
//                bit 1 = script. On a tie the port not granted last wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpu_rr_pick2
  import gpu_hw_regs_pkg::*;
(
  input  wire logic [1:0] eligible,
  input  port_e           last,
  output logic      [1:0] grant
);

  // One-hot grant: pass through a single requester, alternate on a tie.
  always_comb begin
    grant = 2'b00;
    if (eligible == 2'b11) begin
      grant = (last == PORT_HOST) ? 2'b10 : 2'b01;
    end else begin
      grant = eligible;
    end
  end

endmodule : gpu_rr_pick2
`default_nettype wire

// File: rtl/gpu_hw_regs_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_hw_regs_write_arbiter
//  Description : Shares the register-bank write port between the host bus and
//                the script engine. Round-robin, vblank-gated script writes,
//                address window filter with saturating drop counter. All
//                outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpu_hw_regs_write_arbiter
  import gpu_hw_regs_pkg::*;
#(
  parameter int                HW_REGS_SIZE       = HW_REGS_SIZE_DEF,
  parameter logic [ADDR_W-1:0] BASE_WRITE_ADDRESS = BASE_WRITE_ADDRESS_DEF,
  parameter bit                SCR_VBLANK_ONLY    = 1'b1
) (
  input  wire logic                        clk,
  input  wire logic                        rst_n,
  gpu_hw_regs_write_arbiter_if.slave       bus
);

  logic              we_q,       we_d;
  logic              host_ack_q, host_ack_d;
  logic              scr_ack_q,  scr_ack_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] data_q,     data_d;
  logic [7:0]        drop_q,     drop_d;
  port_e             last_q,     last_d;

  logic [1:0]        w_eligible;
  logic [1:0]        w_grant;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_in_window;

  // A port whose ack is high this cycle is masked so one request gives one write.
  assign w_eligible[0] = bus.host_req & ~host_ack_q;
  assign w_eligible[1] = bus.scr_req  & ~scr_ack_q & (bus.vblank | ~SCR_VBLANK_ONLY);

  gpu_rr_pick2 u_pick (
    .eligible (w_eligible),
    .last     (last_q),
    .grant    (w_grant)
  );

  assign w_sel_addr  = w_grant[1] ? bus.scr_addr : bus.host_addr;
  assign w_sel_data  = w_grant[1] ? bus.scr_data : bus.host_data;
  assign w_in_window = (w_sel_addr[ADDR_W-1:HW_REGS_SIZE] ==
                        BASE_WRITE_ADDRESS[ADDR_W-1:HW_REGS_SIZE]);

  // Next-state: acknowledge the grant, then either write or count a drop.
  always_comb begin
    we_d       = 1'b0;
    host_ack_d = w_grant[0];
    scr_ack_d  = w_grant[1];
    addr_d     = addr_q;
    data_d     = data_q;
    drop_d     = drop_q;
    last_d     = last_q;
    if (w_grant != 2'b00) begin
      last_d = w_grant[1] ? PORT_SCR : PORT_HOST;
      if (w_in_window) begin
        we_d   = 1'b1;
        addr_d = w_sel_addr;
        data_d = w_sel_data;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  // Output and round-robin registers; reset makes the host win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      host_ack_q <= 1'b0;
      scr_ack_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      drop_q     <= '0;
      last_q     <= PORT_SCR;
    end else begin
      we_q       <= we_d;
      host_ack_q <= host_ack_d;
      scr_ack_q  <= scr_ack_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      drop_q     <= drop_d;
      last_q     <= last_d;
    end
  end

  assign bus.we       = we_q;
  assign bus.host_ack = host_ack_q;
  assign bus.scr_ack  = scr_ack_q;
  assign bus.addr_out = addr_q;
  assign bus.data_out = data_q;
  assign bus.drop_cnt = drop_q;

endmodule : gpu_hw_regs_write_arbiter
`default_nettype wire

// File: tb/tb_gpu_hw_regs_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpu_hw_regs_write_arbiter
//  Description : Directed self-checking bench for the register write arbiter,
//                with a small register-bank model fed by we/addr_out/data_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpu_hw_regs_write_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  logic [7:0] bank [0:255];

  gpu_hw_regs_write_arbiter_if u_if ();

  gpu_hw_regs_write_arbiter u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank model: captures the write triple on the rising edge.
  always @(posedge clk) begin
    if (u_if.we) bank[u_if.addr_out[7:0]] <= u_if.data_out;
  end

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    u_if.host_req = 1'b0; u_if.host_addr = '0; u_if.host_data = '0;
    u_if.scr_req  = 1'b0; u_if.scr_addr  = '0; u_if.scr_data  = '0;
    u_if.vblank   = 1'b0;
    for (int i = 0; i < 256; i++) bank[i] = 8'h00;
    do_reset();
    n_cmp++;
    if ({u_if.we, u_if.host_ack, u_if.scr_ack} !== 3'b000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 000", {u_if.we, u_if.host_ack, u_if.scr_ack});
    end
    n_cmp++;
    if ({u_if.addr_out, u_if.data_out, u_if.drop_cnt} !== 36'h0) begin
      n_bad++; $display("FAIL reset_data: got %h expected 0", {u_if.addr_out, u_if.data_out, u_if.drop_cnt});
    end
  endtask

  task automatic test_single_write();
    u_if.host_req = 1'b1; u_if.host_addr = 20'h00005; u_if.host_data = 8'hA5;
    step();
    n_cmp++;
    if ({u_if.host_ack, u_if.scr_ack, u_if.we} !== 3'b101) begin
      n_bad++; $display("FAIL single_ack_we: got %b expected 101", {u_if.host_ack, u_if.scr_ack, u_if.we});
    end
    n_cmp++;
    if ({u_if.addr_out, u_if.data_out} !== {20'h00005, 8'hA5}) begin
      n_bad++; $display("FAIL single_bus: got %h expected 00005a5", {u_if.addr_out, u_if.data_out});
    end
    u_if.host_req = 1'b0;
    step();
    n_cmp++;
    if (bank[5] !== 8'hA5) begin
      n_bad++; $display("FAIL single_bank: got %h expected a5", bank[5]);
    end
    n_cmp++;
    if ({u_if.host_ack, u_if.we} !== 2'b00) begin
      n_bad++; $display("FAIL single_idle: got %b expected 00", {u_if.host_ack, u_if.we});
    end
  endtask

  task automatic test_alternate();
    logic exp_host;
    do_reset();
    u_if.vblank   = 1'b1;
    u_if.host_req = 1'b1; u_if.host_addr = 20'h00001; u_if.host_data = 8'h11;
    u_if.scr_req  = 1'b1; u_if.scr_addr  = 20'h00002; u_if.scr_data  = 8'h22;
    for (int i = 0; i < 6; i++) begin
      exp_host = (i % 2 == 0);
      step();
      n_cmp++;
      if ({u_if.host_ack, u_if.scr_ack, u_if.we} !== {exp_host, ~exp_host, 1'b1}) begin
        n_bad++; $display("FAIL alt_grant[%0d]: got %b expected %b", i,
                          {u_if.host_ack, u_if.scr_ack, u_if.we}, {exp_host, ~exp_host, 1'b1});
      end
      n_cmp++;
      if ({u_if.addr_out, u_if.data_out} !== (exp_host ? {20'h00001, 8'h11} : {20'h00002, 8'h22})) begin
        n_bad++; $display("FAIL alt_bus[%0d]: got %h host_expected=%b", i, {u_if.addr_out, u_if.data_out}, exp_host);
      end
    end
    u_if.host_req = 1'b0; u_if.scr_req = 1'b0;
    step();
  endtask

  task automatic test_vblank_gate();
    u_if.vblank  = 1'b0;
    u_if.scr_req = 1'b1; u_if.scr_addr = 20'h00003; u_if.scr_data = 8'h33;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if ({u_if.scr_ack, u_if.we} !== 2'b00) begin
        n_bad++; $display("FAIL vblank_block[%0d]: got %b expected 00", i, {u_if.scr_ack, u_if.we});
      end
    end
    u_if.vblank = 1'b1;
    step();
    n_cmp++;
    if ({u_if.scr_ack, u_if.we, u_if.addr_out, u_if.data_out} !== {2'b11, 20'h00003, 8'h33}) begin
      n_bad++; $display("FAIL vblank_release: got %h expected 30000333", {u_if.scr_ack, u_if.we, u_if.addr_out, u_if.data_out});
    end
    u_if.scr_req = 1'b0;
    step();
    n_cmp++;
    if (bank[3] !== 8'h33) begin
      n_bad++; $display("FAIL vblank_bank: got %h expected 33", bank[3]);
    end
  endtask

  task automatic test_drop();
    u_if.host_req = 1'b1; u_if.host_addr = 20'h00100; u_if.host_data = 8'h77;
    step();
    n_cmp++;
    if ({u_if.host_ack, u_if.we, u_if.drop_cnt} !== {2'b10, 8'h01}) begin
      n_bad++; $display("FAIL drop_first: got %h expected 201", {u_if.host_ack, u_if.we, u_if.drop_cnt});
    end
    n_cmp++;
    if ({u_if.addr_out, u_if.data_out} !== {20'h00003, 8'h33}) begin
      n_bad++; $display("FAIL drop_hold: got %h expected 0000333", {u_if.addr_out, u_if.data_out});
    end
    // Held request is granted every other cycle: step k grants when k is odd.
    for (int k = 2; k <= 600; k++) begin
      step();
      if (k == 507) begin
        n_cmp++;
        if (u_if.drop_cnt !== 8'hFE) begin
          n_bad++; $display("FAIL drop_254: got %h expected fe", u_if.drop_cnt);
        end
      end
      if (k == 509) begin
        n_cmp++;
        if (u_if.drop_cnt !== 8'hFF) begin
          n_bad++; $display("FAIL drop_255: got %h expected ff", u_if.drop_cnt);
        end
      end
    end
    n_cmp++;
    if ({u_if.drop_cnt, u_if.we, u_if.host_ack} !== {8'hFF, 2'b00}) begin
      n_bad++; $display("FAIL drop_sat: got %h expected 3fc", {u_if.drop_cnt, u_if.we, u_if.host_ack});
    end
  endtask

  task automatic test_reset_mid();
    u_if.host_addr = 20'h00007; u_if.host_data = 8'h5A;
    step();
    n_cmp++;
    if ({u_if.host_ack, u_if.we} !== 2'b11) begin
      n_bad++; $display("FAIL mid_pre: got %b expected 11", {u_if.host_ack, u_if.we});
    end
    u_if.scr_req = 1'b1; u_if.scr_addr = 20'h00002; u_if.scr_data = 8'h22;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({u_if.we, u_if.host_ack, u_if.scr_ack, u_if.addr_out, u_if.data_out, u_if.drop_cnt} !== 39'h0) begin
      n_bad++; $display("FAIL mid_async: got %h expected 0",
                        {u_if.we, u_if.host_ack, u_if.scr_ack, u_if.addr_out, u_if.data_out, u_if.drop_cnt});
    end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({u_if.host_ack, u_if.scr_ack, u_if.we, u_if.addr_out} !== {3'b101, 20'h00007}) begin
      n_bad++; $display("FAIL mid_host_first: got %h expected 500007", {u_if.host_ack, u_if.scr_ack, u_if.we, u_if.addr_out});
    end
    step();
    n_cmp++;
    if ({u_if.host_ack, u_if.scr_ack, u_if.we, u_if.addr_out} !== {3'b011, 20'h00002}) begin
      n_bad++; $display("FAIL mid_scr_next: got %h expected 300002", {u_if.host_ack, u_if.scr_ack, u_if.we, u_if.addr_out});
    end
    u_if.host_req = 1'b0; u_if.scr_req = 1'b0;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    u_if.host_req = 1'b1; u_if.host_addr = 20'h00009; u_if.host_data = 8'h99;
    step();
    n_cmp++;
    if ({u_if.host_ack, u_if.we} !== 2'b11) begin
      n_bad++; $display("FAIL b2b_first: got %b expected 11", {u_if.host_ack, u_if.we});
    end
    step();
    n_cmp++;
    if ({u_if.host_ack, u_if.we} !== 2'b00) begin
      n_bad++; $display("FAIL b2b_gap: got %b expected 00", {u_if.host_ack, u_if.we});
    end
    step();
    n_cmp++;
    if ({u_if.host_ack, u_if.we, u_if.addr_out, u_if.data_out} !== {2'b11, 20'h00009, 8'h99}) begin
      n_bad++; $display("FAIL b2b_second: got %h expected 30000999", {u_if.host_ack, u_if.we, u_if.addr_out, u_if.data_out});
    end
    u_if.host_req = 1'b0;
    step();
    n_cmp++;
    if (bank[9] !== 8'h99) begin
      n_bad++; $display("FAIL b2b_bank: got %h expected 99", bank[9]);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    test_reset();
    test_single_write();
    test_alternate();
    test_vblank_gate();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_gpu_hw_regs_write_arbiter
`default_nettype wire
